// File: rtl/serial_pkg.sv
// Shared types and constants for the UART bus-side controller.
// Optional RX prefetch FIFO is enabled with the SERIAL_RX_FIFO_EN macro.
package serial_pkg;

    localparam int unsigned DATA_W              = 8;
    localparam int unsigned CNT_W               = 8;
    localparam int unsigned GUARD_W             = 2;

    localparam int unsigned DEF_RD_PULSE_CYCLES = 2;
    localparam int unsigned DEF_WR_SETUP_CYCLES = 1;
    localparam int unsigned DEF_WR_PULSE_CYCLES = 2;
    localparam int unsigned DEF_RX_DEPTH        = 4;

    // Covers the two synchroniser stages still carrying pre-access flags.
    localparam logic [GUARD_W-1:0] GUARD_INIT   = GUARD_W'(3);

    localparam int unsigned STATUS_RX_BIT       = 1;
    localparam int unsigned STATUS_TX_BIT       = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_PULSE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } state_e;

    // Saturating increment for the strobe-timing counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous RX prefetch FIFO; used only when SERIAL_RX_FIFO_EN is defined.
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RX_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_c_o,
    output logic              full_c_o,
    output logic              empty_c_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    assign empty_c_o = (wr_ptr_q == rd_ptr_q);
    assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push   = push_i & ~full_c_o;
    assign do_pop    = pop_i & ~empty_c_o;
    assign rdata_c_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointers carry one wrap bit to tell full from empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/serial_port_ctrl.sv
// Bus-side UART controller: turns held read/write requests into timed
// rdn/wrn strobes and reports {rx_ready, tx_ready}.
// Define SERIAL_RX_FIFO_EN to add autonomous RX prefetch into a FIFO.
module serial_port_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned RD_PULSE_CYCLES = DEF_RD_PULSE_CYCLES,
    parameter int unsigned WR_SETUP_CYCLES = DEF_WR_SETUP_CYCLES,
    parameter int unsigned WR_PULSE_CYCLES = DEF_WR_PULSE_CYCLES,
    parameter int unsigned RX_DEPTH        = DEF_RX_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              busy,
    output logic [1:0]        status,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              rdn,
    output logic              wrn,
    input  logic              data_ready,
    input  logic              tbre,
    input  logic              tsre
);

    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    // Elaboration-time parameter range checks.
    if (RD_PULSE_CYCLES < 1 || RD_PULSE_CYCLES > CNT_MAX) begin : g_chk_rd
        $error("RD_PULSE_CYCLES must be in 1..255");
    end
    if (WR_SETUP_CYCLES < 1 || WR_SETUP_CYCLES > CNT_MAX) begin : g_chk_ws
        $error("WR_SETUP_CYCLES must be in 1..255");
    end
    if (WR_PULSE_CYCLES < 1 || WR_PULSE_CYCLES > CNT_MAX) begin : g_chk_wp
        $error("WR_PULSE_CYCLES must be in 1..255");
    end
    if (RX_DEPTH < 2 || RX_DEPTH > CNT_MAX || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("RX_DEPTH must be a power of 2 in 2..128");
    end

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WS_LAST = CNT_W'(WR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WP_LAST = CNT_W'(WR_PULSE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic                rdn_q, rdn_d;
    logic                wrn_q, wrn_d;
    logic                bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                done_q, done_d;
    logic [2:0]          sync_meta_q, sync_q;
    logic                data_ready_s, tbre_s, tsre_s;
    logic                rx_ready, tx_ready;

`ifdef SERIAL_RX_FIFO_EN
    logic                prefetch_q, prefetch_d;
    logic [GUARD_W-1:0]  rx_guard_q, rx_guard_d;
    logic                fifo_push, fifo_pop;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full, fifo_empty;

    serial_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .wdata_i   (bus_in),
        .rdata_c_o (fifo_rdata),
        .full_c_o  (fifo_full),
        .empty_c_o (fifo_empty)
    );

    assign rx_ready = ~fifo_empty;
`else
    assign rx_ready = data_ready_s;
`endif

    assign {data_ready_s, tbre_s, tsre_s} = sync_q;
    assign tx_ready = tbre_s & tsre_s & (guard_q == '0) & (state_q == ST_IDLE);

    assign rd_data = rd_data_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE);
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;
    assign rdn     = rdn_q;
    assign wrn     = wrn_q;
    always_comb begin
        status                = '0;
        status[STATUS_RX_BIT] = rx_ready;
        status[STATUS_TX_BIT] = tx_ready;
    end

    // Two-flop synchronisers for the asynchronous UART flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= {data_ready, tbre, tsre};
            sync_q      <= sync_meta_q;
        end
    end

    // State and registered bus-side outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            guard_q   <= '0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            bus_oe_q  <= 1'b0;
            bus_out_q <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            rdn_q     <= rdn_d;
            wrn_q     <= wrn_d;
            bus_oe_q  <= bus_oe_d;
            bus_out_q <= bus_out_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

`ifdef SERIAL_RX_FIFO_EN
    // Prefetch bookkeeping: marks autonomous reads and spaces them out
    // until data_ready has been re-sampled after the strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prefetch_q <= 1'b0;
            rx_guard_q <= '0;
        end else begin
            prefetch_q <= prefetch_d;
            rx_guard_q <= rx_guard_d;
        end
    end
`endif

    // Next-state and strobe sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = sat_inc(cnt_q);
        guard_d   = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
        rdn_d     = rdn_q;
        wrn_d     = wrn_q;
        bus_oe_d  = bus_oe_q;
        bus_out_d = bus_out_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
`ifdef SERIAL_RX_FIFO_EN
        prefetch_d = prefetch_q;
        rx_guard_d = (rx_guard_q != '0) ? rx_guard_q - GUARD_W'(1) : rx_guard_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_read) begin
`ifdef SERIAL_RX_FIFO_EN
                    done_d    = 1'b1;
                    rd_data_d = fifo_empty ? '0 : fifo_rdata;
                    fifo_pop  = ~fifo_empty;
`else
                    if (rx_ready) begin
                        state_d = ST_RD_PULSE;
                        rdn_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        done_d    = 1'b1;
                        rd_data_d = '0;
                    end
`endif
                end else if (req_write) begin
                    state_d = ST_WR_WAIT;
                end
`ifdef SERIAL_RX_FIFO_EN
                else if (data_ready_s && !fifo_full && rx_guard_q == '0) begin
                    state_d    = ST_RD_PULSE;
                    rdn_d      = 1'b0;
                    cnt_d      = '0;
                    prefetch_d = 1'b1;
                end
`endif
            end
            ST_RD_PULSE: begin
                if (cnt_q == RD_LAST) begin
                    rdn_d   = 1'b1;
                    state_d = ST_IDLE;
`ifdef SERIAL_RX_FIFO_EN
                    if (prefetch_q) begin
                        fifo_push  = 1'b1;
                        prefetch_d = 1'b0;
                        rx_guard_d = GUARD_INIT;
                    end else begin
                        rd_data_d = bus_in;
                        done_d    = 1'b1;
                    end
`else
                    rd_data_d = bus_in;
                    done_d    = 1'b1;
`endif
                end
            end
            ST_WR_WAIT: begin
                if (tbre_s && tsre_s && guard_q == '0) begin
                    state_d   = ST_WR_SETUP;
                    bus_out_d = wr_data;
                    bus_oe_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_WR_SETUP: begin
                if (cnt_q == WS_LAST) begin
                    state_d = ST_WR_PULSE;
                    wrn_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_WR_PULSE: begin
                if (cnt_q == WP_LAST) begin
                    state_d = ST_WR_HOLD;
                    wrn_d   = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_d  = ST_IDLE;
                bus_oe_d = 1'b0;
                done_d   = 1'b1;
                guard_d  = GUARD_INIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Self-checking bench for serial_port_ctrl: vector table plus scoreboard
// of expected completions, with hand-written reset/wait/overlap sequences.
module tb_serial_port_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req_read = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] bus_in = 8'h00;
    logic       data_ready = 1'b0;
    logic       tbre = 1'b0;
    logic       tsre = 1'b0;
    logic [7:0] rd_data;
    logic [7:0] bus_out;
    logic       done;
    logic       busy;
    logic       bus_oe;
    logic       rdn;
    logic       wrn;
    logic [1:0] status;

    serial_port_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_read   (req_read),
        .req_write  (req_write),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .done       (done),
        .busy       (busy),
        .status     (status),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .rdn        (rdn),
        .wrn        (wrn),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre)
    );

    always #5 CLK = ~CLK;

    // One transaction: stimulus and expected observations (-1 = not checked).
    typedef struct {
        string      nm;
        bit         is_wr;
        bit         dr;
        logic [7:0] bus_v;
        logic [7:0] wr_v;
        logic [7:0] exp_rd;
        int         exp_rdn;
        int         exp_wrn;
        int         exp_oe;
        int         exp_lat;
    } vec_t;

    vec_t       tbl[$];
    vec_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic [7:0] uart_q[$];
    bit         uart_en = 1'b0;
    logic       prev_rdn = 1'b1;

    function automatic vec_t mk(input string nm, input bit is_wr, input bit dr,
                                input logic [7:0] bv, input logic [7:0] wv,
                                input logic [7:0] er, input int rn, input int wn,
                                input int oe, input int lat);
        vec_t v;
        v.nm = nm; v.is_wr = is_wr; v.dr = dr; v.bus_v = bv; v.wr_v = wv;
        v.exp_rd = er; v.exp_rdn = rn; v.exp_wrn = wn; v.exp_oe = oe; v.exp_lat = lat;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Advance one clock; sample on the falling edge. Optional UART model
    // consumes one byte per completed rdn strobe.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        if (uart_en) begin
            if (prev_rdn == 1'b0 && rdn == 1'b1 && uart_q.size() != 0)
                void'(uart_q.pop_front());
            data_ready = (uart_q.size() != 0);
            bus_in     = (uart_q.size() != 0) ? uart_q[0] : 8'h00;
        end
        prev_rdn = rdn;
    endtask

    // Watch the bus until n_txn done pulses, scoring each against the queue.
    task automatic watch(input int n_txn, input int budget);
        int         seen = 0;
        int         rdn_c = 0;
        int         wrn_c = 0;
        int         oe_c = 0;
        int         ovl = 0;
        int         start = cyc;
        int         extra = 0;
        logic [7:0] cap = 8'h00;
        vec_t       e;
        for (int i = 0; i < budget && seen < n_txn; i++) begin
            tick();
            if (rdn == 1'b0) rdn_c++;
            if (wrn == 1'b0) begin
                if (wrn_c == 0) cap = bus_out;
                wrn_c++;
            end
            if (bus_oe == 1'b1) oe_c++;
            if ((rdn == 1'b0 && wrn == 1'b0) || (rdn == 1'b0 && bus_oe == 1'b1)) ovl++;
            if (done == 1'b1) begin
                seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.nm, "_rd_data"}, int'(rd_data), int'(e.exp_rd));
                    if (e.exp_rdn >= 0) check({e.nm, "_rdn_low"}, rdn_c, e.exp_rdn);
                    if (e.exp_wrn >= 0) check({e.nm, "_wrn_low"}, wrn_c, e.exp_wrn);
                    if (e.exp_oe >= 0)  check({e.nm, "_oe_high"}, oe_c, e.exp_oe);
                    if (e.exp_lat >= 0) check({e.nm, "_latency"}, cyc - start, e.exp_lat);
                    if (e.is_wr)        check({e.nm, "_bus_out"}, int'(cap), int'(e.wr_v));
                    check({e.nm, "_strobe_overlap"}, ovl, 0);
                    if (e.is_wr) req_write = 1'b0;
                    else         req_read  = 1'b0;
                end
                rdn_c = 0; wrn_c = 0; oe_c = 0; ovl = 0; start = cyc;
            end
        end
        if (seen < n_txn) check("watch_timeout", seen, n_txn);
        req_read  = 1'b0;
        req_write = 1'b0;
        repeat (4) begin
            tick();
            if (done == 1'b1) extra++;
        end
        check("no_extra_done", extra, 0);
        check("idle_not_busy", int'(busy), 0);
    endtask

    initial begin
        int   hit;
        int   dcnt;
        vec_t v;

        // Vector table.
`ifndef SERIAL_RX_FIFO_EN
        tbl.push_back(mk("rd_5A",     1'b0, 1'b1, 8'h5A, 8'h00, 8'h5A, 2, 0, 0, 3));
`endif
        tbl.push_back(mk("rd_empty",  1'b0, 1'b0, 8'h33, 8'h00, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk("wr_A5",     1'b1, 1'b0, 8'h00, 8'hA5, 8'h00, 0, 2, 4, 6));
`ifndef SERIAL_RX_FIFO_EN
        tbl.push_back(mk("rd_C3",     1'b0, 1'b1, 8'hC3, 8'h00, 8'hC3, 2, 0, 0, 3));
        tbl.push_back(mk("rd_FF",     1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 2, 0, 0, 3));
`endif
        tbl.push_back(mk("rd_empty2", 1'b0, 1'b0, 8'h77, 8'h00, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk("wr_3C",     1'b1, 1'b0, 8'h00, 8'h3C, 8'h00, 0, 2, 4, 6));

        // Reset values.
        tick();
        tick();
        check("rst_rdn",     int'(rdn), 1);
        check("rst_wrn",     int'(wrn), 1);
        check("rst_bus_oe",  int'(bus_oe), 0);
        check("rst_bus_out", int'(bus_out), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_done",    int'(done), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_status",  int'(status), 0);
        RST  = 1'b0;
        tbre = 1'b1;
        tsre = 1'b1;
        repeat (3) tick();
        check("idle_status_tx_ready", int'(status), 1);

        // Table-driven single transactions.
        for (int i = 0; i < tbl.size(); i++) begin
            v          = tbl[i];
            data_ready = v.dr;
            bus_in     = v.bus_v;
            wr_data    = v.wr_v;
            repeat (5) tick();
            sb.push_back(v);
            if (v.is_wr) req_write = 1'b1;
            else         req_read  = 1'b1;
            watch(1, 60);
        end

        // Write held in WR_WAIT until tbre rises.
        data_ready = 1'b0;
        tbre       = 1'b0;
        wr_data    = 8'hA5;
        repeat (4) tick();
        sb.push_back(mk("wr_wait", 1'b1, 1'b0, 8'h00, 8'hA5, 8'h00, 0, 2, 4, -1));
        req_write = 1'b1;
        repeat (8) tick();
        check("wait_busy",     int'(busy), 1);
        check("wait_wrn",      int'(wrn), 1);
        check("wait_bus_oe",   int'(bus_oe), 0);
        check("wait_tx_ready", int'(status[0]), 0);
        tbre = 1'b1;
        watch(1, 40);

`ifndef SERIAL_RX_FIFO_EN
        // Read and write requested together: read first, then write.
        data_ready = 1'b1;
        bus_in     = 8'h96;
        wr_data    = 8'h69;
        repeat (5) tick();
        sb.push_back(mk("both_rd", 1'b0, 1'b1, 8'h96, 8'h69, 8'h96, 2, 0, 0, 3));
        sb.push_back(mk("both_wr", 1'b1, 1'b1, 8'h96, 8'h69, 8'h96, 0, 2, 4, 6));
        req_read  = 1'b1;
        req_write = 1'b1;
        watch(2, 80);
        data_ready = 1'b0;
`endif

        // Reset in the middle of WR_PULSE.
        repeat (5) tick();
        wr_data   = 8'hE7;
        req_write = 1'b1;
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            tick();
            if (wrn == 1'b0) hit = 1;
        end
        check("rst_mid_reached_pulse", hit, 1);
        RST       = 1'b1;
        req_write = 1'b0;
        tick();
        check("rst_mid_wrn",     int'(wrn), 1);
        check("rst_mid_bus_oe",  int'(bus_oe), 0);
        check("rst_mid_busy",    int'(busy), 0);
        check("rst_mid_done",    int'(done), 0);
        check("rst_mid_rd_data", int'(rd_data), 0);
        RST  = 1'b0;
        dcnt = 0;
        repeat (5) begin
            tick();
            if (done == 1'b1) dcnt++;
        end
        check("rst_mid_no_done",  dcnt, 0);
        check("rst_mid_tx_ready", int'(status[0]), 1);

`ifdef SERIAL_RX_FIFO_EN
        // Five bytes arrive with no requests; four are prefetched.
        uart_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        uart_en = 1'b1;
        repeat (60) tick();
        check("fifo_pending_left", uart_q.size(), 1);
        check("fifo_rx_ready", int'(status[1]), 1);
        sb.push_back(mk("pop0", 1'b0, 1'b1, 8'h00, 8'h00, 8'h11, 0, 0, 0, 1));
        req_read = 1'b1;
        watch(1, 40);
        sb.push_back(mk("pop1", 1'b0, 1'b1, 8'h00, 8'h00, 8'h22, -1, 0, 0, -1));
        req_read = 1'b1;
        watch(1, 40);
        sb.push_back(mk("pop2", 1'b0, 1'b1, 8'h00, 8'h00, 8'h33, -1, 0, 0, -1));
        req_read = 1'b1;
        watch(1, 40);
        sb.push_back(mk("pop3", 1'b0, 1'b1, 8'h00, 8'h00, 8'h44, -1, 0, 0, -1));
        req_read = 1'b1;
        watch(1, 40);
        uart_en = 1'b0;
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
